// File: rtl/imm_decode_stage.sv
// imm_decode_stage: RV32/RV64 immediate decoder behind a one-deep skid buffer.
// Each accepted instruction is decoded combinationally and registered, so its
// result is presented one cycle later. A second entry absorbs one instruction
// while the output is stalled, which lets in_ready be a pure register output.
// Optional feature macro: IMM_DECODE_ILLEGAL_EN. When it is defined, unsupported
// opcodes (and RV32 shifts with instr[25] set) report fmt 7 and out_illegal=1.
module imm_decode_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [15:0]      out_count
);

    typedef enum logic [2:0] {
        FmtR   = 3'd0,
        FmtI   = 3'd1,
        FmtSh  = 3'd2,
        FmtS   = 3'd3,
        FmtB   = 3'd4,
        FmtU   = 3'd5,
        FmtJ   = 3'd6,
        FmtIll = 3'd7
    } fmt_e;

`ifdef IMM_DECODE_ILLEGAL_EN
    localparam fmt_e FmtBad = FmtIll;
`else
    localparam fmt_e FmtBad = FmtR;
`endif

    // Payload layout: {imm, fmt, tag}
    localparam int unsigned PW = XLEN + 3 + TAG_W;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [XLEN-1:0] dec_imm;
    fmt_e            dec_fmt;
    logic [PW-1:0]   dec_payload;

    logic            out_valid_q;
    logic            skid_full_q;
    logic [PW-1:0]   out_q;
    logic [PW-1:0]   skid_q;
    logic [15:0]     count_q;
    logic            out_fire;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];

    // Decode the incoming word into an extended immediate and a format code.
    always_comb begin
        dec_imm = '0;
        dec_fmt = FmtR;
        unique case (opcode)
            7'b0010011: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    if (XLEN == 64) begin
                        dec_imm = XLEN'(in_instr[25:20]);
                        dec_fmt = FmtSh;
                    end else if (in_instr[25]) begin
                        // shamt[5] is reserved on RV32
                        dec_fmt = FmtBad;
                    end else begin
                        dec_imm = XLEN'(in_instr[24:20]);
                        dec_fmt = FmtSh;
                    end
                end else begin
                    dec_imm = XLEN'($signed(in_instr[31:20]));
                    dec_fmt = FmtI;
                end
            end
            7'b0000011, 7'b1100111: begin
                dec_imm = XLEN'($signed(in_instr[31:20]));
                dec_fmt = FmtI;
            end
            7'b0100011: begin
                dec_imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
                dec_fmt = FmtS;
            end
            7'b1100011: begin
                dec_imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                         in_instr[11:8], 1'b0}));
                dec_fmt = FmtB;
            end
            7'b0110111, 7'b0010111: begin
                dec_imm = XLEN'($signed({in_instr[31:12], 12'b0}));
                dec_fmt = FmtU;
            end
            7'b1101111: begin
                dec_imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                         in_instr[30:21], 1'b0}));
                dec_fmt = FmtJ;
            end
            7'b0110011: begin
                dec_fmt = FmtR;
            end
            default: begin
                dec_fmt = FmtBad;
            end
        endcase
    end

    assign dec_payload = {dec_imm, dec_fmt, in_tag};
    assign out_fire    = out_valid_q & out_ready;

    // Output stage plus skid entry; the skid entry always drains before new input.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            skid_full_q <= 1'b0;
            out_q       <= '0;
            skid_q      <= '0;
            count_q     <= '0;
        end else begin
            if (out_fire) begin
                count_q <= count_q + 16'd1;
            end
            if (!out_valid_q || out_ready) begin
                // Output slot is free (empty or handing off) this cycle.
                if (skid_full_q) begin
                    out_q       <= skid_q;
                    out_valid_q <= 1'b1;
                    skid_full_q <= 1'b0;
                end else begin
                    out_valid_q <= in_valid;
                    if (in_valid) begin
                        out_q <= dec_payload;
                    end
                end
            end else if (in_valid && !skid_full_q) begin
                // Output stalled: park the accepted instruction in the skid entry.
                skid_q      <= dec_payload;
                skid_full_q <= 1'b1;
            end
        end
    end

    assign in_ready  = ~skid_full_q;
    assign out_valid = out_valid_q;
    assign out_imm   = out_q[PW-1 -: XLEN];
    assign out_fmt   = out_q[TAG_W +: 3];
    assign out_tag   = out_q[TAG_W-1:0];
    assign out_count = count_q;

`ifdef IMM_DECODE_ILLEGAL_EN
    assign out_illegal = (out_fmt == FmtIll);
`else
    assign out_illegal = 1'b0;
`endif

endmodule

// File: doc/imm_decode_stage.md
IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate output width; legal values 32 or 64.
REQ-002 SHALL have parameter TAG_W, default 5, width of the sideband tag carried alongside each instruction.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream instruction valid.
REQ-006 SHALL have port in_ready  output  1  stage can accept an instruction this cycle.
REQ-007 SHALL have port in_instr  input  32  raw RV32/RV64 instruction word.
REQ-008 SHALL have port in_tag  input  TAG_W  opaque sideband data, returned unmodified.
REQ-009 SHALL have port out_valid  output  1  decoded result valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-011 SHALL have port out_imm  output  XLEN  decoded, extended immediate.
REQ-012 SHALL have port out_fmt  output  3  format code: 0 R/none, 1 I, 2 SH, 3 S, 4 B, 5 U, 6 J, 7 illegal.
REQ-013 SHALL have port out_illegal  output  1  unsupported opcode or shamt flag.
REQ-014 SHALL have port out_tag  output  TAG_W  tag of the instruction currently presented.
REQ-015 SHALL have port out_count  output  16  number of completed output handshakes.

Function
REQ-016 SHALL decode by opcode: 0010011 with funct3 001/101 -> SH, zero-extended shamt instr[24:20] (XLEN=32) or instr[25:20] (XLEN=64).
REQ-017 SHALL decode opcodes 0010011 (other funct3), 0000011, and 1100111 -> I, sign-extended instr[31:20].
REQ-018 SHALL decode 0100011 -> S, sign-extended {instr[31:25], instr[11:7]}.
REQ-019 SHALL decode 1100011 -> B, sign-extended {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
REQ-020 SHALL decode 0110111 and 0010111 -> U, {instr[31:12], 12'b0} sign-extended to XLEN.
REQ-021 SHALL decode 1101111 -> J, sign-extended {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
REQ-022 SHALL decode 0110011 -> fmt 0, imm 0, out_illegal 0; any other opcode -> imm 0, handled per REQ-032.
REQ-023 SHALL set latency to exactly 1 cycle: an instruction accepted at edge N is presented with out_valid=1 after edge N.
REQ-024 SHALL sustain one instruction per cycle while out_ready=1.
REQ-025 SHALL hold the output stage plus one skid entry; a transfer occurs only when valid and ready are both 1.
REQ-026 SHALL drive in_ready = NOT skid_full, a registered signal with no combinational path from out_ready.
REQ-027 SHALL, when the output is stalled and an input is accepted, capture it in the skid entry; on the next output handshake, move the skid entry to the output.
REQ-028 SHALL keep out_imm, out_fmt, out_illegal and out_tag stable while out_valid=1 and out_ready=0; SHALL preserve order with no loss or duplication.
REQ-029 SHALL increment out_count on each output handshake, wrapping from 0xFFFF to 0x0000.

Reset
REQ-030 SHALL, while reset=1 at a clock edge, clear out_valid, skid entry, out_imm, out_fmt, out_illegal, out_tag and out_count to 0, and drive in_ready to 1 from the following cycle.
REQ-031 SHALL discard in-flight and skid contents when reset is asserted mid-operation; no handshake completes in a reset cycle.

Configuration
REQ-032 SHALL use macro IMM_DECODE_ILLEGAL_EN: when defined, unsupported opcodes and SH with instr[25]=1 at XLEN=32 give fmt 7, out_illegal 1; when undefined, they give fmt 0 and out_illegal is tied to 0.

Verification
REQ-033 SHALL cover: 0xFFF00093 (addi -1) -> one cycle later out_imm=0xFFFFFFFF, fmt 1.
REQ-034 SHALL cover: 0x4030D093 (srai 3) -> out_imm=0x00000003, fmt 2; 0xFE000EE3 (beq -4) -> out_imm=0xFFFFFFFC, fmt 4.
REQ-035 SHALL cover: three back-to-back instructions with out_ready=0 for 3 cycles -> in_ready=0 after the second is accepted, outputs held stable, then all three delivered in order.
REQ-036 SHALL cover: 0x0000007F -> out_imm=0, with IMM_DECODE_ILLEGAL_EN fmt 7 and out_illegal 1; without it, fmt 0 and out_illegal 0.
REQ-037 SHALL cover: reset asserted with both entries full -> next cycle out_valid=0, in_ready=1, out_count=0.
REQ-038 SHALL cover: 65537 handshakes -> out_count=0x0001.
